// File: rtl/reg4_arbiter.sv
// Round-robin arbiter that serialises load/clear/set/read requests onto one shared
// set/reset register, one three-cycle IDLE -> EXEC -> DONE transaction at a time.
module reg4_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      rdata,
  output logic              busy,
  output logic [W-1:0]      reg_d,
  output logic              reg_set,
  output logic              reg_clr,
  input  logic [W-1:0]      reg_q
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpClr  = 2'b01;
  localparam logic [1:0] OpSet  = 2'b10;
  localparam logic [1:0] OpRead = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic            set_q, set_d;
  logic            clr_q, clr_d;
  logic [W-1:0]    rdata_q, rdata_d;

  logic [1:0]      op_arr [NREQ];
  logic [W-1:0]    wd_arr [NREQ];
  logic            found;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] cand_idx;
  int unsigned     cand;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_arr[i] = op[2*i +: 2];
      wd_arr[i] = wdata[W*i +: W];
    end
  end

  // Rotating priority: search starts one past the previous winner.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_q) + k) % NREQ;
      cand_idx = IdxW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // set/clr are registered on entry to EXEC so the register pins never glitch.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    set_d   = 1'b0;
    clr_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StExec;
          win_d   = pick;
          op_d    = op_arr[pick];
          wdata_d = wd_arr[pick];
          set_d   = (op_arr[pick] == OpSet);
          clr_d   = (op_arr[pick] == OpClr);
        end
      end
      StExec: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        last_d  = win_q;
        rdata_d = reg_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      win_q   <= '0;
      last_q  <= IdxW'(NREQ - 1);
      op_q    <= OpRead;
      wdata_q <= '0;
      set_q   <= 1'b0;
      clr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      set_q   <= set_d;
      clr_q   <= clr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    gnt = '0;
    ack = '0;
    if (state_q == StExec) gnt[win_q] = 1'b1;
    if (state_q == StDone) ack[win_q] = 1'b1;
  end

  // In DONE the register already shows the post-op value, so pass it straight through.
  assign rdata   = (state_q == StDone) ? reg_q : rdata_q;
  assign busy    = (state_q != StIdle);
  assign reg_d   = (state_q == StExec && op_q == OpLoad) ? wdata_q : reg_q;
  assign reg_set = set_q;
  assign reg_clr = clr_q;

endmodule

// File: tb/tb_reg4_arbiter.sv
// Bench for reg4_arbiter: drives a behavioural set/async-clear register and checks
// grants, acks and returned data against a scoreboard of expected completions.
module tb_reg4_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned W    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [2*NREQ-1:0] op = '1;
  logic [W*NREQ-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt, ack;
  logic [W-1:0]      rdata, reg_d, reg_q;
  logic              busy, reg_set, reg_clr;
  logic [W-1:0]      reg_val = '0;

  always #5 clk = ~clk;

  reg4_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .reg_d(reg_d), .reg_set(reg_set), .reg_clr(reg_clr), .reg_q(reg_q)
  );

  // Shared register: asynchronous clear, synchronous set, otherwise loads D.
  always @(posedge clk or posedge reg_clr) begin
    if (reg_clr === 1'b1)            reg_val <= '0;
    else if (reg_set === 1'b1)       reg_val <= '1;
    else if (!$isunknown(reg_d))     reg_val <= reg_d;
  end
  assign reg_q = reg_val;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [W-1:0]    data;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] model_val = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int idx, input logic [1:0] o, input logic [W-1:0] d);
    op[2*idx +: 2]    = o;
    wdata[W*idx +: W] = d;
  endtask

  task automatic apply_model(input logic [1:0] o, input logic [W-1:0] d);
    case (o)
      2'b00:   model_val = d;
      2'b01:   model_val = '0;
      2'b10:   model_val = '1;
      default: model_val = model_val;
    endcase
  endtask

  task automatic push_exp(input int idx, input logic [1:0] o, input logic [W-1:0] d);
    exp_t e;
    apply_model(o, d);
    e.ack  = NREQ'(1) << idx;
    e.data = model_val;
    sb.push_back(e);
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a, output logic [W-1:0] d, output int cyc);
    a   = '0;
    d   = '0;
    cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        a   = ack;
        d   = rdata;
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    req = '1;
    op  = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({gnt, ack, busy, rdata, reg_set, reg_clr} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: gnt=%b ack=%b busy=%b rdata=%b set=%b clr=%b, want all 0",
                 gnt, ack, busy, rdata, reg_set, reg_clr);
      end
    end
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || gnt !== '0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b gnt=%b, want 0/000", busy, gnt);
    end
  endtask

  task automatic test_load();
    exp_t e;
    set_req(0, 2'b00, 4'b1010);
    req = 3'b001;
    push_exp(0, 2'b00, 4'b1010);
    @(negedge clk);
    n_vec++;
    if (gnt !== 3'b001 || busy !== 1'b1 || reg_d !== 4'b1010 || reg_set !== 1'b0 ||
        reg_clr !== 1'b0) begin
      n_err++;
      $display("FAIL load_exec: gnt=%b busy=%b reg_d=%b set=%b clr=%b, want 001/1/1010/0/0",
               gnt, busy, reg_d, reg_set, reg_clr);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (ack !== e.ack || rdata !== e.data || reg_q !== 4'b1010 || gnt !== '0) begin
      n_err++;
      $display("FAIL load_done: ack=%b rdata=%b reg_q=%b gnt=%b, want %b/%b/1010/000",
               ack, rdata, reg_q, gnt, e.ack, e.data);
    end
    req = '0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || ack !== '0 || rdata !== 4'b1010) begin
      n_err++;
      $display("FAIL load_hold: busy=%b ack=%b rdata=%b, want 0/000/1010", busy, ack, rdata);
    end
  endtask

  task automatic test_clear_set();
    exp_t e;
    set_req(1, 2'b01, 4'b0000);
    req = 3'b010;
    push_exp(1, 2'b01, 4'b0000);
    @(negedge clk);
    n_vec++;
    if (gnt !== 3'b010 || reg_clr !== 1'b1 || reg_set !== 1'b0) begin
      n_err++;
      $display("FAIL clear_exec: gnt=%b clr=%b set=%b, want 010/1/0", gnt, reg_clr, reg_set);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (ack !== e.ack || rdata !== e.data || reg_clr !== 1'b0) begin
      n_err++;
      $display("FAIL clear_done: ack=%b rdata=%b clr=%b, want %b/%b/0",
               ack, rdata, reg_clr, e.ack, e.data);
    end
    req = '0;
    @(negedge clk);
    set_req(2, 2'b10, 4'b0000);
    req = 3'b100;
    push_exp(2, 2'b10, 4'b0000);
    @(negedge clk);
    n_vec++;
    if (gnt !== 3'b100 || reg_set !== 1'b1 || reg_clr !== 1'b0) begin
      n_err++;
      $display("FAIL set_exec: gnt=%b set=%b clr=%b, want 100/1/0", gnt, reg_set, reg_clr);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (ack !== e.ack || rdata !== e.data || reg_set !== 1'b0) begin
      n_err++;
      $display("FAIL set_done: ack=%b rdata=%b set=%b, want %b/%b/0",
               ack, rdata, reg_set, e.ack, e.data);
    end
    req = '0;
    @(negedge clk);
  endtask

  // Hold req continuously and check the fixed EXEC/DONE/IDLE cadence cycle by cycle.
  task automatic run_rotation(input string name, input logic [NREQ-1:0] r,
                              input int order [3], input int rounds);
    exp_t            e;
    int              who;
    logic [NREQ-1:0] exp_gnt;
    for (int t = 0; t < rounds; t++) push_exp(order[t % 3], 2'b11, 4'b0000);
    req = r;
    for (int c = 0; c < 3 * rounds; c++) begin
      @(negedge clk);
      who     = order[(c / 3) % 3];
      exp_gnt = (c % 3 == 0) ? NREQ'(1) << who : '0;
      n_vec++;
      if (gnt !== exp_gnt || busy !== (c % 3 != 2)) begin
        n_err++;
        $display("FAIL %s_gnt c=%0d: gnt=%b busy=%b, want %b/%b",
                 name, c, gnt, busy, exp_gnt, (c % 3 != 2));
      end
      if (c % 3 == 1) begin
        e = sb.pop_front();
        n_vec++;
        if (ack !== e.ack || rdata !== e.data) begin
          n_err++;
          $display("FAIL %s_ack c=%0d: ack=%b rdata=%b, want %b/%b",
                   name, c, ack, rdata, e.ack, e.data);
        end
      end else begin
        n_vec++;
        if (ack !== '0) begin
          n_err++;
          $display("FAIL %s_noack c=%0d: ack=%b, want 000", name, c, ack);
        end
      end
      if (c == 3 * rounds - 1) req = '0;
    end
  endtask

  task automatic test_round_robin();
    int order [3];
    order = '{0, 1, 2};
    op = '1;
    run_rotation("rr", 3'b111, order, 6);
  endtask

  task automatic test_priority();
    int order [3];
    order = '{1, 2, 1};
    op    = '1;
    reset = 1'b1;
    req   = 3'b110;
    @(negedge clk);
    n_vec++;
    if (gnt !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL prio_reset_wins: gnt=%b busy=%b, want 000/0", gnt, busy);
    end
    reset = 1'b0;
    run_rotation("prio", 3'b110, order, 3);
  endtask

  task automatic test_reset_exec();
    logic [NREQ-1:0] a;
    logic [W-1:0]    d;
    int              cyc;
    exp_t            e;
    set_req(0, 2'b00, 4'b0101);
    req = 3'b001;
    @(negedge clk);
    n_vec++;
    if (gnt !== 3'b001) begin
      n_err++;
      $display("FAIL rstx_exec: gnt=%b, want 001", gnt);
    end
    reset = 1'b1;
    req   = '0;
    apply_model(2'b00, 4'b0101);
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({gnt, ack, busy, reg_set, reg_clr} !== '0 || rdata !== '0) begin
      n_err++;
      $display("FAIL rstx_abort: gnt=%b ack=%b busy=%b set=%b clr=%b rdata=%b, want all 0",
               gnt, ack, busy, reg_set, reg_clr, rdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (ack !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rstx_noack i=%0d: ack=%b busy=%b, want 000/0", i, ack, busy);
      end
    end
    set_req(0, 2'b11, 4'b0000);
    req = 3'b001;
    push_exp(0, 2'b11, 4'b0000);
    wait_ack(a, d, cyc);
    req = '0;
    e   = sb.pop_front();
    n_vec++;
    if (cyc != 2 || a !== e.ack || d !== e.data || reg_q !== e.data) begin
      n_err++;
      $display("FAIL rstx_read: cyc=%0d ack=%b rdata=%b reg_q=%b, want 2/%b/%b/%b",
               cyc, a, d, reg_q, e.ack, e.data, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_idle_hold();
    logic [NREQ-1:0] a;
    logic [W-1:0]    d;
    int              cyc;
    exp_t            e;
    set_req(1, 2'b00, 4'b0110);
    req = 3'b010;
    push_exp(1, 2'b00, 4'b0110);
    wait_ack(a, d, cyc);
    req = '0;
    e   = sb.pop_front();
    n_vec++;
    if (cyc != 2 || a !== e.ack || d !== e.data) begin
      n_err++;
      $display("FAIL idle_load: cyc=%0d ack=%b rdata=%b, want 2/%b/%b",
               cyc, a, d, e.ack, e.data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (reg_d !== 4'b0110 || reg_q !== 4'b0110 || reg_set !== 1'b0 || reg_clr !== 1'b0 ||
          busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_hold i=%0d: reg_d=%b reg_q=%b set=%b clr=%b busy=%b, want 0110/0110/0/0/0",
                 i, reg_d, reg_q, reg_set, reg_clr, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_clear_set();
    test_round_robin();
    test_priority();
    test_reset_exec();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
